pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have port: clk  in  1  pipeline clock; all state updates on rising edge.
REQ-002 SHALL have port: clrn  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: id_rs, id_rt  in  5 each  source register numbers of instruction in ID.
REQ-004 SHALL have port: id_use_rs, id_use_rt  in  1 each  ID instruction reads rs / rt.
REQ-005 SHALL have port: id_wreg, id_m2reg  in  1 each  ID instruction writes regfile / is a load.
REQ-006 SHALL have port: id_rn  in  5  ID destination register.
REQ-007 SHALL have port: branch_taken  in  1  branch/jump resolved taken in ID this cycle.
REQ-008 SHALL have port: mem_ready  in  1  data memory can complete this cycle; 0 = wait.
REQ-009 SHALL have port: pipe_en  out  1  global enable for IF/ID, ID/EXE, EXE/MEM, MEM/WB registers.
REQ-010 SHALL have port: wpcir  out  1  write enable for PC and IF/ID.
REQ-011 SHALL have port: idexe_bubble  out  1  force all ID/EXE control bits (m2reg, wmem, wreg, aluc, aluimm, shift) to 0.
REQ-012 SHALL have port: ifid_flush  out  1  load IF/ID with a NOP.
REQ-013 SHALL have port: fwda, fwdb  out  2 each  operand A/B select: 00 regfile, 01 EXE ALU result, 10 MEM ALU result, 11 MEM load data.
REQ-014 SHALL have port: ctrl_state  out  2  current FSM state.
REQ-015 SHALL have port: stall_cycles, flush_count  out  16 each  saturating performance counters.

Function
REQ-016 SHALL keep an internal scoreboard: e_wreg, e_m2reg, e_rn (EXE slot) and m_wreg, m_m2reg, m_rn (MEM slot).
REQ-017 On each edge with pipe_en=1: MEM slot <= EXE slot; EXE slot <= ID values, or all zero when idexe_bubble=1.
REQ-018 On each edge with pipe_en=0: scoreboard SHALL hold.
REQ-019 Register 0 SHALL never match: any comparison against rn=0 is false.
REQ-020 load-use hazard = e_wreg & e_m2reg & e_rn!=0 & ((id_use_rs & id_rs==e_rn) | (id_use_rt & id_rt==e_rn)).
REQ-021 fwda: 01 if EXE match, non-load; else 10 if MEM match, non-load; else 11 if MEM match, load; else 00. fwdb identical using id_rt. EXE has priority over MEM.
REQ-022 FSM states: RUN=0, LU_STALL=1, FREEZE=2; encoding 3 unused, SHALL recover to RUN.
REQ-023 Transition priority: mem_ready=0 -> FREEZE from any state; else load-use hazard -> LU_STALL; else RUN.
REQ-024 FREEZE (mem_ready=0, combinational): pipe_en=0, wpcir=0, idexe_bubble=0, ifid_flush=0.
REQ-025 Load-use (mem_ready=1): pipe_en=1, wpcir=0, idexe_bubble=1, ifid_flush=0; stall lasts exactly one cycle, then forwarding selects 11.
REQ-026 branch_taken with no stall: ifid_flush=1 for that cycle only, wpcir=1.
REQ-027 branch_taken coinciding with load-use or freeze: stall wins, no flush; branch re-evaluated next cycle.
REQ-028 Otherwise: pipe_en=1, wpcir=1, idexe_bubble=0, ifid_flush=0.
REQ-029 stall_cycles +1 per edge where wpcir=0; flush_count +1 per edge where ifid_flush=1; both saturate at 0xFFFF.

Reset
REQ-030 clrn=0 SHALL immediately clear scoreboard, counters, ctrl_state=RUN.
REQ-031 During and after reset: pipe_en=1, wpcir=1, idexe_bubble=0, ifid_flush=0, fwda=fwdb=00.
REQ-032 Reset mid-freeze or mid-stall SHALL abandon the stall; first cycle after release is RUN.

Structure
REQ-033 pipe_ctrl_pkg SHALL hold state encodings and FWD_RF/FWD_EXE/FWD_MEM/FWD_LOAD constants.
REQ-034 Scoreboard SHALL be sub-module hazard_scoreboard (EXE/MEM shadow slots with enable and bubble input).

Verification
REQ-035 lw r3 then add r4,r3,r5 -> one cycle wpcir=0, idexe_bubble=1; next cycle fwda=11; stall_cycles=1.
REQ-036 add r3 then sub r6,r3,r3 -> fwda=fwdb=01, no stall; with one independent instr between -> 10.
REQ-037 add r0,... then use r0 -> fwda=00, no stall.
REQ-038 mem_ready=0 for 3 cycles -> pipe_en=0, ctrl_state=FREEZE 3 cycles, scoreboard unchanged, stall_cycles+=3.
REQ-039 branch_taken with load-use same cycle -> no flush that cycle; flush next cycle; flush_count=1.
REQ-040 clrn pulsed low during FREEZE -> outputs at reset values, RUN after release, counters 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states, forwarding
// selects, the scoreboard slot record and the operand forwarding decision.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_LU_STALL = 2'd1,
      ST_FREEZE   = 2'd2,
      ST_UNUSED   = 2'd3
   } ctrl_state_t;

   localparam logic [1:0] FWD_RF   = 2'b00;
   localparam logic [1:0] FWD_EXE  = 2'b01;
   localparam logic [1:0] FWD_MEM  = 2'b10;
   localparam logic [1:0] FWD_LOAD = 2'b11;

   typedef struct packed {
      logic       wreg;
      logic       m2reg;
      logic [4:0] rn;
   } slot_t;

   // r0 never matches; a load still sitting in EXE is not forwardable from EXE.
   function automatic logic [1:0] fwd_sel(input logic [4:0] r, input slot_t e, input slot_t m);
      if (e.wreg && !e.m2reg && (e.rn != 5'd0) && (e.rn == r))
         return FWD_EXE;
      else if (m.wreg && (m.rn != 5'd0) && (m.rn == r))
         return m.m2reg ? FWD_LOAD : FWD_MEM;
      else
         return FWD_RF;
   endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Shadow copies of the destination info held in the EXE and MEM pipeline slots.
module hazard_scoreboard
   import pipe_ctrl_pkg::*;
(
   input  logic  clk,
   input  logic  clrn,
   input  logic  en,
   input  logic  bubble,
   input  slot_t id_slot,
   output slot_t e_slot,
   output slot_t m_slot
);

   slot_t e_reg, m_reg;

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         e_reg <= '0;
         m_reg <= '0;
      end else if (en) begin
         m_reg <= e_reg;
         e_reg <= bubble ? '0 : id_slot;
      end
   end

   assign e_slot = e_reg;
   assign m_slot = m_reg;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard control for a 5-stage pipeline: load-use stall, memory-wait freeze,
// branch flush, operand forwarding and saturating stall/flush counters.
module pipeline_hazard_ctrl
   import pipe_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        clrn,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        id_use_rs,
   input  logic        id_use_rt,
   input  logic        id_wreg,
   input  logic        id_m2reg,
   input  logic [4:0]  id_rn,
   input  logic        branch_taken,
   input  logic        mem_ready,
   output logic        pipe_en,
   output logic        wpcir,
   output logic        idexe_bubble,
   output logic        ifid_flush,
   output logic [1:0]  fwda,
   output logic [1:0]  fwdb,
   output logic [1:0]  ctrl_state,
   output logic [15:0] stall_cycles,
   output logic [15:0] flush_count
);

   ctrl_state_t state_reg, state_next;
   slot_t       id_slot, e_slot, m_slot;
   logic        load_use;
   logic [15:0] stall_reg, flush_reg;

   assign id_slot = '{wreg: id_wreg, m2reg: id_m2reg, rn: id_rn};

   hazard_scoreboard u_scoreboard (
      .clk     (clk),
      .clrn    (clrn),
      .en      (pipe_en),
      .bubble  (idexe_bubble),
      .id_slot (id_slot),
      .e_slot  (e_slot),
      .m_slot  (m_slot)
   );

   assign load_use = e_slot.wreg && e_slot.m2reg && (e_slot.rn != 5'd0) &&
                     ((id_use_rs && (id_rs == e_slot.rn)) ||
                      (id_use_rt && (id_rt == e_slot.rn)));

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn)
         state_reg <= ST_RUN;
      else
         state_reg <= state_next;
   end

   // Outputs follow the current inputs; the state register only records
   // which condition applied, so the unused encoding simply falls back to RUN.
   always_comb begin
      state_next   = ST_RUN;
      pipe_en      = 1'b1;
      wpcir        = 1'b1;
      idexe_bubble = 1'b0;
      ifid_flush   = 1'b0;
      if (!mem_ready) begin
         state_next = ST_FREEZE;
         pipe_en    = 1'b0;
         wpcir      = 1'b0;
      end else if (load_use) begin
         state_next   = ST_LU_STALL;
         wpcir        = 1'b0;
         idexe_bubble = 1'b1;
      end else if (branch_taken) begin
         ifid_flush = 1'b1;
      end
      if (!clrn) begin
         pipe_en      = 1'b1;
         wpcir        = 1'b1;
         idexe_bubble = 1'b0;
         ifid_flush   = 1'b0;
      end
   end

   assign fwda = clrn ? fwd_sel(id_rs, e_slot, m_slot) : FWD_RF;
   assign fwdb = clrn ? fwd_sel(id_rt, e_slot, m_slot) : FWD_RF;

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         stall_reg <= '0;
         flush_reg <= '0;
      end else begin
         if (!wpcir && (stall_reg != 16'hFFFF))
            stall_reg <= stall_reg + 16'd1;
         if (ifid_flush && (flush_reg != 16'hFFFF))
            flush_reg <= flush_reg + 16'd1;
      end
   end

   assign ctrl_state   = state_reg;
   assign stall_cycles = stall_reg;
   assign flush_count  = flush_reg;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: forwarding, load-use, freeze, branch, reset.
module tb_pipeline_hazard_ctrl;

   logic        clk = 1'b0;
   logic        clrn;
   logic [4:0]  id_rs, id_rt, id_rn;
   logic        id_use_rs, id_use_rt, id_wreg, id_m2reg;
   logic        branch_taken, mem_ready;
   logic        pipe_en, wpcir, idexe_bubble, ifid_flush;
   logic [1:0]  fwda, fwdb, ctrl_state;
   logic [15:0] stall_cycles, flush_count;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl dut (
      .clk          (clk),
      .clrn         (clrn),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_use_rs    (id_use_rs),
      .id_use_rt    (id_use_rt),
      .id_wreg      (id_wreg),
      .id_m2reg     (id_m2reg),
      .id_rn        (id_rn),
      .branch_taken (branch_taken),
      .mem_ready    (mem_ready),
      .pipe_en      (pipe_en),
      .wpcir        (wpcir),
      .idexe_bubble (idexe_bubble),
      .ifid_flush   (ifid_flush),
      .fwda         (fwda),
      .fwdb         (fwdb),
      .ctrl_state   (ctrl_state),
      .stall_cycles (stall_cycles),
      .flush_count  (flush_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // pipe_en, wpcir, idexe_bubble, ifid_flush packed as a 4-bit word
   task automatic chk_ctl(input string tag, input logic [3:0] exp);
      chk(tag, {28'd0, pipe_en, wpcir, idexe_bubble, ifid_flush}, {28'd0, exp});
   endtask

   task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                         input logic urt, input logic wr, input logic m2, input logic [4:0] rn);
      id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
      id_wreg = wr; id_m2reg = m2; id_rn = rn;
      #1;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      clrn = 1'b0; mem_ready = 1'b1; branch_taken = 1'b0;
      set_id(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
      chk_ctl("reset_ctl", 4'b1100);
      chk("reset_fwd", {30'd0, fwda} << 2 | fwdb, 32'd0);
      chk("reset_state", ctrl_state, 32'd0);
      chk("reset_stall", stall_cycles, 32'd0);
      chk("reset_flush", flush_count, 32'd0);
      repeat (2) @(posedge clk);
      #1 clrn = 1'b1;

      // lw r3 ; add r4,r3,r5
      set_id(5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3);
      chk_ctl("lw_issue_ctl", 4'b1100);
      tick;
      set_id(5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 5'd4);
      chk_ctl("lu_stall_ctl", 4'b1010);
      chk("lu_stall_state", ctrl_state, 32'd0);
      tick;
      chk_ctl("lu_after_ctl", 4'b1100);
      chk("lu_after_fwda", fwda, 32'd3);
      chk("lu_after_fwdb", fwdb, 32'd0);
      chk("lu_after_state", ctrl_state, 32'd1);
      chk("lu_stall_cycles", stall_cycles, 32'd1);
      tick;

      // add r3 ; sub r6,r3,r3 ; or r7,r3,r6
      set_id(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3);
      chk("indep_fwda", fwda, 32'd0);
      chk("indep_state", ctrl_state, 32'd0);
      tick;
      set_id(5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 5'd6);
      chk_ctl("exe_fwd_ctl", 4'b1100);
      chk("exe_fwda", fwda, 32'd1);
      chk("exe_fwdb", fwdb, 32'd1);
      tick;
      set_id(5'd3, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 5'd7);
      chk("mem_fwda", fwda, 32'd2);
      chk("exe_pri_fwdb", fwdb, 32'd1);
      tick;

      // add r0 ; use r0 ; lw r0 ; use r0
      set_id(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0);
      tick;
      set_id(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd8);
      chk("r0_exe_fwda", fwda, 32'd0);
      chk("r0_exe_fwdb", fwdb, 32'd0);
      tick;
      set_id(5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0);
      chk("r0_mem_fwda", fwda, 32'd0);
      tick;
      set_id(5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
      chk_ctl("r0_load_nostall", 4'b1100);
      tick;

      // add r10 ; add r11,r10 under 3 cycles of memory wait
      set_id(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd10);
      tick;
      set_id(5'd10, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd11);
      mem_ready = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk_ctl($sformatf("freeze%0d_ctl", i), 4'b0000);
         chk($sformatf("freeze%0d_fwda", i), fwda, 32'd1);
         chk($sformatf("freeze%0d_state", i), ctrl_state, (i == 0) ? 32'd0 : 32'd2);
         tick;
      end
      mem_ready = 1'b1;
      #1;
      chk_ctl("unfreeze_ctl", 4'b1100);
      chk("unfreeze_state", ctrl_state, 32'd2);
      chk("unfreeze_fwda", fwda, 32'd1);
      chk("freeze_stall_cycles", stall_cycles, 32'd4);
      tick;
      chk("post_freeze_state", ctrl_state, 32'd0);

      // lw r12 ; taken branch on r12
      set_id(5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd12);
      tick;
      branch_taken = 1'b1;
      set_id(5'd12, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
      chk_ctl("br_lu_ctl", 4'b1010);
      tick;
      chk_ctl("br_flush_ctl", 4'b1101);
      chk("br_flush_fwda", fwda, 32'd3);
      chk("br_flush_count0", flush_count, 32'd0);
      tick;
      branch_taken = 1'b0;
      set_id(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
      chk_ctl("br_done_ctl", 4'b1100);
      chk("br_flush_count1", flush_count, 32'd1);
      chk("br_stall_cycles", stall_cycles, 32'd5);

      // reset pulse during freeze
      mem_ready = 1'b0;
      tick;
      tick;
      chk("pre_rst_state", ctrl_state, 32'd2);
      chk("pre_rst_stall", stall_cycles, 32'd7);
      chk_ctl("pre_rst_ctl", 4'b0000);
      #2 clrn = 1'b0;
      #1;
      chk_ctl("mid_rst_ctl", 4'b1100);
      chk("mid_rst_state", ctrl_state, 32'd0);
      chk("mid_rst_stall", stall_cycles, 32'd0);
      chk("mid_rst_flush", flush_count, 32'd0);
      tick;
      chk_ctl("held_rst_ctl", 4'b1100);
      mem_ready = 1'b1;
      clrn = 1'b1;
      #1;
      chk("post_rst_state", ctrl_state, 32'd0);
      tick;
      chk("post_rst_run", ctrl_state, 32'd0);
      chk("post_rst_stall", stall_cycles, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
